// File: rtl/result_checker.sv
// Run-based result checker: compares four observed channels against programmable expected
// values in a window of a fixed-length run. Optional capture of {d,c,b,a}: RESULT_CHECKER_CAPTURE_EN.
module result_checker #(
  parameter int CHECK_CYCLE = 3,
  parameter int NUM_CHECKS  = 1,
  parameter int RUN_CYCLES  = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [7:0]  c,
  input  logic [7:0]  d,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_idx,
  input  logic [7:0]  cfg_data,
  input  logic [3:0]  cfg_mask,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  err_cnt,
  output logic [3:0]  err_vec,
  output logic [7:0]  cycle_cnt,
  output logic [31:0] cap_data,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {IDLE, WAIT, CHECK, RUN, DONE} state_t;

  localparam logic [7:0] CHECK_AT = 8'(CHECK_CYCLE);
  localparam logic [7:0] RUN_LAST = 8'(RUN_CYCLES - 1);
  localparam logic [3:0] CHK_LAST = 4'(NUM_CHECKS - 1);

  state_t          state_q, state_d;
  logic [7:0]      cycle_q, cycle_d, cycle_inc;
  logic [3:0]      chk_q, chk_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0][7:0] exp_val_q, exp_val_d;
  logic [3:0]      err_cnt_q, err_cnt_d;
  logic [3:0]      err_vec_q, err_vec_d;
  logic            pass_q, pass_d;
  logic [31:0]     obs_w;
  logic [3:0]      mismatch;
  logic [4:0]      err_sum;
  logic [3:0]      err_sat;
  logic            busy_w, start_ok;

  assign obs_w    = {d, c, b, a};
  assign busy_w   = (state_q == WAIT) || (state_q == CHECK) || (state_q == RUN);
  assign start_ok = start && !busy_w;

  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q;
    chk_d     = chk_q;
    mask_d    = mask_q;
    exp_val_d = exp_val_q;
    err_cnt_d = err_cnt_q;
    err_vec_d = err_vec_q;
    pass_d    = pass_q;
    cycle_inc = cycle_q + 8'd1;

    mismatch = 4'b0000;
    err_sum  = {1'b0, err_cnt_q};
    for (int i = 0; i < 4; i++) begin
      mismatch[i] = mask_q[i] && (obs_w[8*i +: 8] != exp_val_q[i]);
      err_sum     = err_sum + 5'(mismatch[i]);
    end
    err_sat = (err_sum > 5'd15) ? 4'd15 : err_sum[3:0];

    // The write lands in the same edge as a start, so the run sees the new value.
    if (cfg_we && !busy_w) exp_val_d[cfg_idx] = cfg_data;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          cycle_d   = 8'd0;
          chk_d     = 4'd0;
          mask_d    = cfg_mask;
          err_cnt_d = 4'd0;
          err_vec_d = 4'd0;
          pass_d    = 1'b0;
          state_d   = (CHECK_CYCLE == 0) ? CHECK : WAIT;
        end
      end
      WAIT: begin
        cycle_d = cycle_inc;
        if (cycle_inc == CHECK_AT) state_d = CHECK;
      end
      CHECK: begin
        cycle_d   = cycle_inc;
        err_cnt_d = err_sat;
        err_vec_d = err_vec_q | mismatch;
        if (chk_q == CHK_LAST) begin
          if (cycle_inc >= RUN_LAST) begin
            state_d = DONE;
            pass_d  = (err_sat == 4'd0);
          end else begin
            state_d = RUN;
          end
        end else begin
          chk_d = chk_q + 4'd1;
        end
      end
      RUN: begin
        cycle_d = cycle_inc;
        if (cycle_inc == RUN_LAST) begin
          state_d = DONE;
          pass_d  = (err_cnt_q == 4'd0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cycle_q   <= 8'd0;
      chk_q     <= 4'd0;
      mask_q    <= 4'd0;
      exp_val_q <= '0;
      err_cnt_q <= 4'd0;
      err_vec_q <= 4'd0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      chk_q     <= chk_d;
      mask_q    <= mask_d;
      exp_val_q <= exp_val_d;
      err_cnt_q <= err_cnt_d;
      err_vec_q <= err_vec_d;
      pass_q    <= pass_d;
    end
  end

`ifdef RESULT_CHECKER_CAPTURE_EN
  logic [31:0] cap_q, cap_d;

  // Snapshot taken on the edge that closes the first compare cycle.
  always_comb begin
    cap_d = cap_q;
    if (start_ok) cap_d = 32'd0;
    else if (state_q == CHECK && chk_q == 4'd0) cap_d = obs_w;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cap_q <= 32'd0;
    else      cap_q <= cap_d;
  end

  assign cap_data = cap_q;
`else
  assign cap_data = 32'd0;
`endif

  assign busy      = busy_w;
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign err_vec   = err_vec_q;
  assign cycle_cnt = cycle_q;
  assign dbg_state = state_q;

endmodule
